// File: rtl/aes_pkg.sv
// Shared AES scheduling definitions: block geometry, round count, scheduler states
// and the channel-index width helper.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_NR    = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } sched_state_t;

    // Width of a channel index; never narrower than one bit so a two-channel build still has an index.
    function automatic int ch_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr,
// wrapping from N-1 back to 0.
module rr_arbiter
    import aes_pkg::*;
#(
    parameter int N = 4,
    parameter int W = ch_idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    logic [W:0]   pos;
    logic [W-1:0] cand;

    // Scan from the farthest offset down to ptr itself so the nearest requester is the last one written.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        pos  = '0;
        cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (W + 1)'(i);
            if (pos >= (W + 1)'(N)) begin
                pos = pos - (W + 1)'(N);
            end
            cand = pos[W-1:0];
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/aes_job_sched.sv
// Shares one iterative AES-128 core between NUM_CH requesters: round-robin job
// acceptance, a single start-level pass per job, and a per-channel result handshake.
module aes_job_sched
    import aes_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int NR     = AES_NR,
    parameter int TMO    = 13
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_CH-1:0]             req_valid,
    output logic [NUM_CH-1:0]             req_ready,
    input  logic [NUM_CH*AES_BLK_W-1:0]   req_pt,
    input  logic [NUM_CH*AES_BLK_W-1:0]   req_key,
    output logic                          core_start,
    output logic [AES_BLK_W-1:0]          core_pt,
    output logic [AES_BLK_W-1:0]          core_key,
    input  logic                          core_done,
    input  logic [AES_BLK_W-1:0]          core_ct,
    output logic [NUM_CH-1:0]             rsp_valid,
    input  logic [NUM_CH-1:0]             rsp_ready,
    output logic [AES_BLK_W-1:0]          rsp_ct,
    output logic                          rsp_err,
    output logic                          busy
);

    localparam int CW = ch_idx_w(NUM_CH);
    // A timeout shorter than a full pass would abort healthy jobs, so it is clamped to NR+2.
    localparam int TMO_EFF = (TMO > NR + 1) ? TMO : NR + 2;
    localparam int TW = $clog2(TMO_EFF + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_EFF - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);

    sched_state_t      state;
    sched_state_t      next_state;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     cur_ch;
    logic [TW-1:0]     tmo_cnt;
    logic [NUM_CH-1:0] gnt;
    logic [CW-1:0]     gnt_idx;
    logic [NUM_CH-1:0] cur_sel;
    logic              rsp_hs;
    logic              timed_out;

    rr_arbiter #(
        .N(NUM_CH),
        .W(CW)
    ) u_arb (
        .req(req_valid),
        .ptr(rr_ptr),
        .gnt(gnt),
        .idx(gnt_idx)
    );

    assign cur_sel   = NUM_CH'(1) << cur_ch;
    assign rsp_hs    = (state == RESP) && rsp_ready[cur_ch];
    assign timed_out = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // req_ready is also masked by rstn so it reads zero while reset is held, not just after it.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        rsp_valid  = '0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = rstn ? gnt : '0;
                if (|req_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (core_done || timed_out) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = cur_sel;
                if (rsp_hs) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // core_start drops on the edge where the controller wraps NR->0, leaving the core parked at round 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr     <= '0;
            cur_ch     <= '0;
            tmo_cnt    <= '0;
            core_start <= 1'b0;
            core_pt    <= '0;
            core_key   <= '0;
            rsp_ct     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        core_pt    <= req_pt[gnt_idx*AES_BLK_W +: AES_BLK_W];
                        core_key   <= req_key[gnt_idx*AES_BLK_W +: AES_BLK_W];
                        cur_ch     <= gnt_idx;
                        core_start <= 1'b1;
                        tmo_cnt    <= '0;
                    end
                end
                RUN: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (core_done) begin
                        rsp_ct     <= core_ct;
                        rsp_err    <= 1'b0;
                        core_start <= 1'b0;
                    end else if (timed_out) begin
                        rsp_ct     <= '0;
                        rsp_err    <= 1'b1;
                        core_start <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rr_ptr <= (cur_ch == LAST_CH) ? '0 : cur_ch + CW'(1);
                    end
                end
                default: begin
                    core_start <= 1'b0;
                end
            endcase
        end
    end

    a_req_ready_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready));
    a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(rsp_valid));
    a_start_only_in_run: assert property (@(posedge clk) disable iff (!rstn) core_start |-> (state == RUN));

endmodule
